// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants, descriptor classes and immediate formats.
// Also holds the program writer's FSM state type.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_RTYPE  = 7'h33;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_ITYPE  = 7'h13;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    localparam logic [2:0] F3_WORD = 3'b010;

    typedef enum logic [2:0] {
        CLS_LOAD   = 3'd0,
        CLS_STORE  = 3'd1,
        CLS_RTYPE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_ITYPE  = 3'd4,
        CLS_LUI    = 3'd5,
        CLS_JAL    = 3'd6,
        CLS_RSVD   = 3'd7
    } desc_class_e;

    // Codes match the decode stage's ImmSrc control.
    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } wr_state_e;

    function automatic imm_src_e imm_src_of(desc_class_e cls);
        case (cls)
            CLS_STORE:  return IMM_S;
            CLS_BRANCH: return IMM_B;
            CLS_JAL:    return IMM_J;
            CLS_LUI:    return IMM_U;
            default:    return IMM_I;
        endcase
    endfunction

    // Scatters the immediate into its instruction bit positions; all other bits zero.
    function automatic logic [31:0] place_imm(imm_src_e src, logic [31:0] imm);
        case (src)
            IMM_S:   return {imm[11:5], 13'b0, imm[4:0], 7'b0};
            IMM_B:   return {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
            IMM_J:   return {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
            IMM_U:   return {imm[31:12], 12'b0};
            default: return {imm[11:0], 20'b0};
        endcase
    endfunction

endpackage

// File: rtl/imem_program_writer_if.sv
// Descriptor handshake, IMEM write port and status bundle of the program writer.
interface imem_program_writer_if #(
    parameter int ADDR_W = 6
) ();
    logic              start;
    logic              desc_valid;
    logic              desc_ready;
    logic [2:0]        desc_class;
    logic [2:0]        desc_funct3;
    logic              desc_funct7_5;
    logic [4:0]        desc_rd;
    logic [4:0]        desc_rs1;
    logic [4:0]        desc_rs2;
    logic [31:0]       desc_imm;
    logic              desc_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic              err_illegal;
    logic              err_full;
    logic [ADDR_W:0]   word_count;

    modport master (
        output start, desc_valid, desc_class, desc_funct3, desc_funct7_5,
               desc_rd, desc_rs1, desc_rs2, desc_imm, desc_last,
        input  desc_ready, imem_we, imem_addr, imem_wdata, busy, done,
               err_illegal, err_full, word_count
    );

    modport slave (
        input  start, desc_valid, desc_class, desc_funct3, desc_funct7_5,
               desc_rd, desc_rs1, desc_rs2, desc_imm, desc_last,
        output desc_ready, imem_we, imem_addr, imem_wdata, busy, done,
               err_illegal, err_full, word_count
    );
endinterface

// File: rtl/instr_encoder.sv
// Combinational map from an instruction descriptor to a 32-bit RV32I word.
module instr_encoder
    import riscv_pkg::*;
(
    input  logic [2:0]  class_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7_5_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o
);
    desc_class_e cls;
    logic [31:0] imm_field;

    assign cls = desc_class_e'(class_i);

    always_comb begin
        imm_field = place_imm(imm_src_of(cls), imm_i);
        word_o    = '0;
        case (cls)
            CLS_LOAD:   word_o = imm_field | {12'b0, rs1_i, F3_WORD, rd_i, OP_LOAD};
            CLS_STORE:  word_o = imm_field | {7'b0, rs2_i, rs1_i, F3_WORD, 5'b0, OP_STORE};
            CLS_RTYPE:  word_o = {1'b0, funct7_5_i, 5'b0, rs2_i, rs1_i, funct3_i, rd_i, OP_RTYPE};
            CLS_BRANCH: word_o = imm_field | {7'b0, rs2_i, rs1_i, funct3_i, 5'b0, OP_BRANCH};
            CLS_ITYPE: begin
                word_o = imm_field | {12'b0, rs1_i, funct3_i, rd_i, OP_ITYPE};
                // srli/srai share funct3 101; bit 30 selects arithmetic shift.
                if (funct3_i == 3'b101) word_o[30] = funct7_5_i;
            end
            CLS_LUI:    word_o = imm_field | {20'b0, rd_i, OP_LUI};
            CLS_JAL:    word_o = imm_field | {20'b0, rd_i, OP_JAL};
            default:    word_o = '0;
        endcase
    end
endmodule

// File: rtl/imem_program_writer.sv
// Accepts instruction descriptors, encodes them and writes them to consecutive
// IMEM word addresses starting at 0, one word every two cycles.
module imem_program_writer
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    imem_program_writer_if.slave  bus
);
    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    wr_state_e         state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   count_q;
    logic [31:0]       wdata_q;
    logic [31:0]       wdata_d;
    logic              last_q;
    logic              ready_q;
    logic              we_q;
    logic              busy_q;
    logic              done_q;
    logic              err_illegal_q;
    logic              err_full_q;

    instr_encoder u_encoder (
        .class_i    (bus.desc_class),
        .funct3_i   (bus.desc_funct3),
        .funct7_5_i (bus.desc_funct7_5),
        .rd_i       (bus.desc_rd),
        .rs1_i      (bus.desc_rs1),
        .rs2_i      (bus.desc_rs2),
        .imm_i      (bus.desc_imm),
        .word_o     (wdata_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            count_q       <= '0;
            wdata_q       <= '0;
            last_q        <= 1'b0;
            ready_q       <= 1'b0;
            we_q          <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_illegal_q <= 1'b0;
            err_full_q    <= 1'b0;
        end else if (bus.start) begin
            // start overrides any handshake or pending write in this cycle
            state_q       <= ST_ACCEPT;
            ptr_q         <= '0;
            count_q       <= '0;
            ready_q       <= 1'b1;
            we_q          <= 1'b0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            err_illegal_q <= 1'b0;
            err_full_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_ACCEPT: begin
                    if (bus.desc_valid && ready_q) begin
                        if (bus.desc_class == CLS_RSVD) begin
                            err_illegal_q <= 1'b1;
                        end else begin
                            wdata_q <= wdata_d;
                            last_q  <= bus.desc_last;
                            ready_q <= 1'b0;
                            we_q    <= 1'b1;
                            state_q <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    we_q    <= 1'b0;
                    ptr_q   <= ptr_q + ADDR_W'(1);
                    count_q <= count_q + (ADDR_W+1)'(1);
                    if (last_q || ptr_q == PTR_MAX) begin
                        state_q    <= ST_DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        err_full_q <= !last_q;
                    end else begin
                        state_q <= ST_ACCEPT;
                        ready_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.desc_ready  = ready_q;
    assign bus.imem_we     = we_q;
    assign bus.imem_addr   = ptr_q;
    assign bus.imem_wdata  = wdata_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err_illegal = err_illegal_q;
    assign bus.err_full    = err_full_q;
    assign bus.word_count  = count_q;
endmodule

// File: doc/imem_program_writer.md
# imem_program_writer

Sequential instruction producer for the pipelined RV32I core. It accepts instruction descriptors over a valid/ready handshake and encodes each into a 32-bit word, using the opcode subset the decode stage recognises: lw, sw, R-type, beq/branch, I-type ALU, lui and jal. It writes the words to consecutive instruction-memory addresses. It fills IMEM before the core is released from reset, and it is used by benches to load programs.

## Interface
Parameters:
- `ADDR_W`, default 6: IMEM word-address width. Depth is 2^ADDR_W words.

Ports:
- `clk`  in  1  Single clock. All logic is rising-edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `start`  in  1  Pulse. Begins a load session at word address 0.
- `desc_valid`  in  1  A descriptor is present on the `desc_*` inputs.
- `desc_ready`  out  1  The block can accept a descriptor.
- `desc_class`  in  3  0 LOAD, 1 STORE, 2 RTYPE, 3 BRANCH, 4 ITYPE, 5 LUI, 6 JAL, 7 reserved.
- `desc_funct3`  in  3  funct3 field.
- `desc_funct7_5`  in  1  Instruction bit 30 (sub/sra/srai).
- `desc_rd`, `desc_rs1`, `desc_rs2`  in  5 each  Register indices.
- `desc_imm`  in  32  Byte-offset or immediate value.
- `desc_last`  in  1  Marks the final descriptor of the session.
- `imem_we`  out  1  IMEM write strobe.
- `imem_addr`  out  ADDR_W  IMEM word address.
- `imem_wdata`  out  32  Encoded instruction word.
- `busy`  out  1  A session is active.
- `done`  out  1  Sticky. Set when the session ends.
- `err_illegal`  out  1  Sticky. A class-7 descriptor was received.
- `err_full`  out  1  Sticky. The session ended because IMEM filled.
- `word_count`  out  ADDR_W+1  Number of words written in this session.

## Operation
- FSM states: IDLE, ACCEPT, WRITE, DONE.
- IDLE or DONE -> ACCEPT on `start`. On this transition:
  - address pointer := 0, `word_count` := 0.
  - `done`, `err_illegal` and `err_full` are cleared.
- ACCEPT:
  - `desc_ready` = 1.
  - On `desc_valid && desc_ready`, the encoded word and `desc_last` are registered and the FSM moves to WRITE.
- WRITE:
  - `imem_we` = 1 for exactly one cycle, at the current pointer.
  - The pointer and `word_count` increment at the end of the cycle.
  - Next state is DONE if the registered last flag is set or the pointer equals 2^ADDR_W-1. Otherwise ACCEPT.
  - When DONE is entered because the pointer hit 2^ADDR_W-1 without the last flag, `err_full` is set.
- DONE: `done` = 1 and `desc_ready` = 0 until the next `start`.
- `start` while busy restarts the session. The pointer goes to 0, the FSM goes to ACCEPT, and any write not yet issued is dropped.
- Class 7 in ACCEPT:
  - The descriptor is consumed and `err_illegal` is set.
  - Nothing is written, the pointer is unchanged, and the FSM stays in ACCEPT.
- Encoding rules:
  - Opcodes: LOAD 0x03, STORE 0x23, RTYPE 0x33, BRANCH 0x63, ITYPE 0x13, LUI 0x37, JAL 0x6F.
  - Formats: LOAD and ITYPE use I-format. STORE uses S. BRANCH uses B, built from imm[12:1]. LUI uses U, built from imm[31:12]. JAL uses J, built from imm[20:1].
  - Fields a format does not use are zero.
  - LOAD and STORE force funct3 = 010. JAL and LUI ignore funct3.
  - Bit 30 = `desc_funct7_5` only for RTYPE, and for ITYPE with funct3 = 101. In every other case bit 30 follows the immediate.
  - Immediate bits above each format's range are ignored. No range check is made.

## Timing
- Reset values: FSM = IDLE, pointer = 0. All outputs are 0: `desc_ready`, `imem_we`, `imem_addr`, `imem_wdata`, `busy`, `done`, `err_illegal`, `err_full` and `word_count`.
- `busy` = 1 in ACCEPT and WRITE.
- Latency: a handshake in cycle N produces `imem_we` in cycle N+1. `imem_addr` and `imem_wdata` are registered and stable while `imem_we` = 1.
- Throughput: one word per 2 cycles.
- `desc_ready` does not depend combinationally on `desc_valid`.
- Reset asserted mid-session: immediate return to IDLE with all outputs at 0. A write in progress is aborted.
- `start` and a handshake in the same cycle: `start` wins and the descriptor is not consumed.

## Structure
- Shared package `riscv_pkg` holds:
  - the opcode constants 0x03/0x23/0x33/0x63/0x13/0x37/0x6F;
  - the descriptor-class enum;
  - the ImmSrc format codes (I 000, S 001, B 010, J 011, U 100), shared with the decode stage.
- Sub-module `instr_encoder` is purely combinational and maps a descriptor to a 32-bit word. The FSM, pointer and error flags live in the top module.

## Test plan
- RTYPE, rd 3, rs1 1, rs2 2, f3 0, f7_5 0 -> 0x002081B3 at address 0. The same descriptor with f7_5 1 -> 0x402081B3.
- LOAD, rd 5, rs1 2, imm 8 -> 0x00812283. STORE, rs1 2, rs2 5, imm 12 -> 0x00512623.
- BRANCH, rs1 1, rs2 2, f3 0, imm -4 -> 0xFE208EE3. JAL, rd 1, imm 8 -> 0x008000EF. LUI, rd 4, imm 0x12345000 -> 0x12345237.
- Three descriptors, the third with `desc_last` -> writes at addresses 0, 1, 2 on cycles N+1, N+3, N+5. Then `done` = 1, `word_count` = 3, `desc_ready` = 0.
- A class-7 descriptor between two valid ones -> `err_illegal` = 1, the valid words land at addresses 0 and 1 with no gap, `word_count` = 2.
- With ADDR_W = 2, five descriptors and no last -> four writes, then DONE with `err_full` = 1 and the fifth descriptor not accepted. A following `start` -> address 0, `err_full` cleared. `rst_n` low mid-session -> all outputs 0 asynchronously.
